// File: rtl/noc_out_port_arbiter_if.sv
// Handshake bundle between the rx FIFO heads, one output-port arbiter and its tx link PHY.
interface noc_out_port_arbiter_if #(
   parameter int NUM_REQ   = 4,
   parameter int REQ_IDX_W = $clog2(NUM_REQ)
);
   logic [NUM_REQ-1:0]   req_i;
   logic [NUM_REQ-1:0]   last_i;
   logic                 stall_i;
   logic [NUM_REQ-1:0]   grant_o;
   logic [REQ_IDX_W-1:0] sel_o;
   logic [NUM_REQ-1:0]   rdreq_o;
   logic                 wrreq_o;
   logic                 busy_o;
   logic                 wdog_err_o;

   modport master (
      output req_i, last_i, stall_i,
      input  grant_o, sel_o, rdreq_o, wrreq_o, busy_o, wdog_err_o
   );

   modport slave (
      input  req_i, last_i, stall_i,
      output grant_o, sel_o, rdreq_o, wrreq_o, busy_o, wdog_err_o
   );
endinterface

// File: rtl/noc_out_port_arbiter.sv
// Round-robin wormhole arbiter for one NoC tx port; grant is held from head to tail flit.
// Optional stuck-packet watchdog enabled by defining ARB_WATCHDOG_EN.
module noc_out_port_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int REQ_IDX_W   = $clog2(NUM_REQ),
   parameter int WDOG_CYCLES = 1024
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   noc_out_port_arbiter_if.slave bus
);
   typedef enum logic {IDLE, LOCKED} state_e;

   state_e               state_q, state_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [REQ_IDX_W-1:0] sel_q, sel_d;
   logic [REQ_IDX_W-1:0] ptr_q, ptr_d;
   logic [REQ_IDX_W-1:0] pick, sel_inc;
   logic                 found;
   logic                 xfer;
   logic                 wdog_hit;

   if (NUM_REQ < 2 || WDOG_CYCLES < 2) begin : g_bad_params
      $error("noc_out_port_arbiter: NUM_REQ and WDOG_CYCLES must be at least 2");
   end

   // First requester at or above ptr, wrapping past NUM_REQ-1.
   always_comb begin
      int idx;
      found = 1'b0;
      pick  = '0;
      idx   = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(ptr_q) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && bus.req_i[idx]) begin
            found = 1'b1;
            pick  = REQ_IDX_W'(idx);
         end
      end
   end

   assign sel_inc = (int'(sel_q) == NUM_REQ - 1) ? '0 : sel_q + 1'b1;
   assign xfer    = (state_q == LOCKED) && bus.req_i[sel_q] && !bus.stall_i && !reset_i;

   assign bus.grant_o = grant_q;
   assign bus.sel_o   = sel_q;
   assign bus.rdreq_o = grant_q & {NUM_REQ{xfer}};
   assign bus.wrreq_o = xfer;
   assign bus.busy_o  = (state_q == LOCKED);

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d       = LOCKED;
               grant_d       = '0;
               grant_d[pick] = 1'b1;
               sel_d         = pick;
            end
         end
         LOCKED: begin
            if ((xfer && bus.last_i[sel_q]) || wdog_hit) begin
               state_d = IDLE;
               grant_d = '0;
               ptr_d   = sel_inc;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         grant_q <= '0;
         sel_q   <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
      end
   end

`ifdef ARB_WATCHDOG_EN
   localparam int WDOG_W = $clog2(WDOG_CYCLES);

   logic [WDOG_W-1:0] wdog_q, wdog_d;

   // Counts consecutive locked cycles without a transfer; a same-cycle transfer wins.
   assign wdog_hit = (state_q == LOCKED) && !xfer && !reset_i &&
                     (wdog_q == WDOG_W'(WDOG_CYCLES - 1));

   always_comb begin
      wdog_d = wdog_q + 1'b1;
      if (state_q != LOCKED || xfer || wdog_hit) wdog_d = '0;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) wdog_q <= '0;
      else         wdog_q <= wdog_d;
   end

   assign bus.wdog_err_o = wdog_hit;
`else
   assign wdog_hit       = 1'b0;
   assign bus.wdog_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_noc_out_port_arbiter.sv
// Directed bench for noc_out_port_arbiter (4 requesters, watchdog limit 8 when enabled).
module tb_noc_out_port_arbiter;
   logic clk = 1'b0;
   logic reset_i = 1'b1;
   int   checks = 0;
   int   errors = 0;

   noc_out_port_arbiter_if #(.NUM_REQ(4)) bus ();

   noc_out_port_arbiter #(.NUM_REQ(4), .WDOG_CYCLES(8)) dut (
      .clk_i   (clk),
      .reset_i (reset_i),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   // One cycle: new inputs just after the edge, outputs settle before the check.
   task automatic drive(input logic [3:0] req, input logic [3:0] last, input logic stall);
      @(posedge clk);
      #1;
      bus.req_i   = req;
      bus.last_i  = last;
      bus.stall_i = stall;
      #1;
   endtask

   task automatic test_reset();
      bus.req_i = 4'b1111; bus.last_i = 4'b1111; bus.stall_i = 1'b0;
      drive(4'b1111, 4'b1111, 1'b0);
      drive(4'b1111, 4'b1111, 1'b0);
      checks++;
      if (bus.grant_o !== 4'b0000 || bus.sel_o !== 2'd0 || bus.busy_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_state grant=%b sel=%0d busy=%b exp grant=0000 sel=0 busy=0",
                  bus.grant_o, bus.sel_o, bus.busy_o);
      end
      checks++;
      if (bus.wrreq_o !== 1'b0 || bus.rdreq_o !== 4'b0000 || bus.wdog_err_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_strobes wrreq=%b rdreq=%b wdog=%b exp 0/0000/0",
                  bus.wrreq_o, bus.rdreq_o, bus.wdog_err_o);
      end
      bus.req_i = 4'b0000;
      reset_i   = 1'b0;
   endtask

   task automatic test_single_packet();
      drive(4'b0100, 4'b0000, 1'b0);
      checks++;
      if (bus.grant_o !== 4'b0000 || bus.wrreq_o !== 1'b0) begin
         errors++;
         $display("FAIL sp_arb_cycle grant=%b wrreq=%b exp 0000/0", bus.grant_o, bus.wrreq_o);
      end
      for (int f = 0; f < 3; f++) begin
         drive(4'b0100, (f == 2) ? 4'b0100 : 4'b0000, 1'b0);
         checks++;
         if (bus.grant_o !== 4'b0100 || bus.sel_o !== 2'd2 || bus.wrreq_o !== 1'b1 ||
             bus.rdreq_o !== 4'b0100) begin
            errors++;
            $display("FAIL sp_flit%0d grant=%b sel=%0d wrreq=%b rdreq=%b exp 0100/2/1/0100",
                     f + 1, bus.grant_o, bus.sel_o, bus.wrreq_o, bus.rdreq_o);
         end
      end
      drive(4'b0000, 4'b0000, 1'b0);
      checks++;
      if (bus.grant_o !== 4'b0000 || bus.busy_o !== 1'b0 || bus.wrreq_o !== 1'b0) begin
         errors++;
         $display("FAIL sp_idle grant=%b busy=%b wrreq=%b exp 0000/0/0",
                  bus.grant_o, bus.busy_o, bus.wrreq_o);
      end
      // ptr must now be 3: with everyone requesting, input 3 wins.
      drive(4'b1111, 4'b1111, 1'b0);
      drive(4'b1111, 4'b1111, 1'b0);
      checks++;
      if (bus.grant_o !== 4'b1000 || bus.wrreq_o !== 1'b1) begin
         errors++;
         $display("FAIL sp_ptr3 grant=%b wrreq=%b exp 1000/1", bus.grant_o, bus.wrreq_o);
      end
      drive(4'b0000, 4'b0000, 1'b0);
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_g [5];
      exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
      exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
      for (int p = 0; p < 5; p++) begin
         drive(4'b1111, 4'b0000, 1'b0);
         checks++;
         if (bus.grant_o !== 4'b0000 || bus.wrreq_o !== 1'b0) begin
            errors++;
            $display("FAIL rr_gap%0d grant=%b wrreq=%b exp 0000/0", p, bus.grant_o, bus.wrreq_o);
         end
         drive(4'b1111, 4'b0000, 1'b0);
         checks++;
         if (bus.grant_o !== exp_g[p] || bus.wrreq_o !== 1'b1) begin
            errors++;
            $display("FAIL rr_grant%0d grant=%b wrreq=%b exp %b/1",
                     p, bus.grant_o, bus.wrreq_o, exp_g[p]);
         end
         drive(4'b1111, 4'b1111, 1'b0);
         checks++;
         if (bus.rdreq_o !== exp_g[p] || bus.wrreq_o !== 1'b1) begin
            errors++;
            $display("FAIL rr_tail%0d rdreq=%b wrreq=%b exp %b/1",
                     p, bus.rdreq_o, bus.wrreq_o, exp_g[p]);
         end
      end
      drive(4'b0000, 4'b0000, 1'b0);
   endtask

   task automatic test_stall();
      drive(4'b0010, 4'b0000, 1'b0);
      drive(4'b0010, 4'b0000, 1'b0);
      checks++;
      if (bus.grant_o !== 4'b0010 || bus.wrreq_o !== 1'b1) begin
         errors++;
         $display("FAIL st_head grant=%b wrreq=%b exp 0010/1", bus.grant_o, bus.wrreq_o);
      end
      for (int s = 0; s < 5; s++) begin
         drive(4'b0010, 4'b0010, 1'b1);
         checks++;
         if (bus.grant_o !== 4'b0010 || bus.wrreq_o !== 1'b0 || bus.rdreq_o !== 4'b0000) begin
            errors++;
            $display("FAIL st_stall%0d grant=%b wrreq=%b rdreq=%b exp 0010/0/0000",
                     s, bus.grant_o, bus.wrreq_o, bus.rdreq_o);
         end
      end
      drive(4'b0010, 4'b0010, 1'b0);
      checks++;
      if (bus.wrreq_o !== 1'b1 || bus.rdreq_o !== 4'b0010) begin
         errors++;
         $display("FAIL st_tail wrreq=%b rdreq=%b exp 1/0010", bus.wrreq_o, bus.rdreq_o);
      end
      drive(4'b0000, 4'b0000, 1'b0);
      checks++;
      if (bus.grant_o !== 4'b0000 || bus.busy_o !== 1'b0) begin
         errors++;
         $display("FAIL st_idle grant=%b busy=%b exp 0000/0", bus.grant_o, bus.busy_o);
      end
   endtask

   task automatic test_req_drop();
      drive(4'b1001, 4'b0000, 1'b0);
      drive(4'b1001, 4'b0000, 1'b0);
      checks++;
      if (bus.grant_o !== 4'b1000 || bus.rdreq_o !== 4'b1000) begin
         errors++;
         $display("FAIL rd_head grant=%b rdreq=%b exp 1000/1000", bus.grant_o, bus.rdreq_o);
      end
      for (int d = 0; d < 4; d++) begin
         drive(4'b0001, 4'b0000, 1'b0);
         checks++;
         if (bus.grant_o !== 4'b1000 || bus.rdreq_o !== 4'b0000 || bus.wrreq_o !== 1'b0) begin
            errors++;
            $display("FAIL rd_hold%0d grant=%b rdreq=%b wrreq=%b exp 1000/0000/0",
                     d, bus.grant_o, bus.rdreq_o, bus.wrreq_o);
         end
      end
      drive(4'b1001, 4'b1000, 1'b0);
      checks++;
      if (bus.rdreq_o !== 4'b1000 || bus.wrreq_o !== 1'b1) begin
         errors++;
         $display("FAIL rd_tail rdreq=%b wrreq=%b exp 1000/1", bus.rdreq_o, bus.wrreq_o);
      end
      drive(4'b0001, 4'b0000, 1'b0);
      drive(4'b0001, 4'b0001, 1'b0);
      checks++;
      if (bus.grant_o !== 4'b0001 || bus.wrreq_o !== 1'b1) begin
         errors++;
         $display("FAIL rd_wrap grant=%b wrreq=%b exp 0001/1", bus.grant_o, bus.wrreq_o);
      end
      drive(4'b0000, 4'b0000, 1'b0);
   endtask

   task automatic test_reset_mid_packet();
      drive(4'b0100, 4'b0000, 1'b0);
      drive(4'b0100, 4'b0000, 1'b0);
      drive(4'b0100, 4'b0000, 1'b0);
      reset_i = 1'b1;
      #1;
      checks++;
      if (bus.wrreq_o !== 1'b0 || bus.rdreq_o !== 4'b0000) begin
         errors++;
         $display("FAIL rm_reset_cycle wrreq=%b rdreq=%b exp 0/0000", bus.wrreq_o, bus.rdreq_o);
      end
      drive(4'b0011, 4'b0000, 1'b0);
      reset_i = 1'b0;
      checks++;
      if (bus.grant_o !== 4'b0000 || bus.wrreq_o !== 1'b0 || bus.busy_o !== 1'b0) begin
         errors++;
         $display("FAIL rm_after grant=%b wrreq=%b busy=%b exp 0000/0/0",
                  bus.grant_o, bus.wrreq_o, bus.busy_o);
      end
      drive(4'b0011, 4'b0001, 1'b0);
      checks++;
      if (bus.grant_o !== 4'b0001 || bus.sel_o !== 2'd0 || bus.wrreq_o !== 1'b1) begin
         errors++;
         $display("FAIL rm_first grant=%b sel=%0d wrreq=%b exp 0001/0/1",
                  bus.grant_o, bus.sel_o, bus.wrreq_o);
      end
      drive(4'b0000, 4'b0000, 1'b0);
   endtask

   task automatic test_watchdog();
      logic exp_w;
      drive(4'b1100, 4'b0000, 1'b0);
      drive(4'b1100, 4'b0000, 1'b0);
      checks++;
      if (bus.grant_o !== 4'b0100 || bus.wrreq_o !== 1'b1) begin
         errors++;
         $display("FAIL wd_head grant=%b wrreq=%b exp 0100/1", bus.grant_o, bus.wrreq_o);
      end
      for (int k = 1; k <= 8; k++) begin
         drive(4'b1000, 4'b0000, 1'b0);
         exp_w = 1'b0;
`ifdef ARB_WATCHDOG_EN
         exp_w = (k == 8);
`endif
         checks++;
         if (bus.wdog_err_o !== exp_w || bus.grant_o !== 4'b0100 || bus.wrreq_o !== 1'b0) begin
            errors++;
            $display("FAIL wd_cycle%0d wdog=%b grant=%b wrreq=%b exp %b/0100/0",
                     k, bus.wdog_err_o, bus.grant_o, bus.wrreq_o, exp_w);
         end
      end
`ifdef ARB_WATCHDOG_EN
      drive(4'b1000, 4'b0000, 1'b0);
      checks++;
      if (bus.grant_o !== 4'b0000 || bus.wdog_err_o !== 1'b0 || bus.busy_o !== 1'b0) begin
         errors++;
         $display("FAIL wd_release grant=%b wdog=%b busy=%b exp 0000/0/0",
                  bus.grant_o, bus.wdog_err_o, bus.busy_o);
      end
`else
      drive(4'b1100, 4'b0100, 1'b0);
      checks++;
      if (bus.grant_o !== 4'b0100 || bus.wrreq_o !== 1'b1 || bus.wdog_err_o !== 1'b0) begin
         errors++;
         $display("FAIL wd_held_tail grant=%b wrreq=%b wdog=%b exp 0100/1/0",
                  bus.grant_o, bus.wrreq_o, bus.wdog_err_o);
      end
      drive(4'b1000, 4'b0000, 1'b0);
`endif
      drive(4'b1000, 4'b1000, 1'b0);
      checks++;
      if (bus.grant_o !== 4'b1000 || bus.wrreq_o !== 1'b1) begin
         errors++;
         $display("FAIL wd_next grant=%b wrreq=%b exp 1000/1", bus.grant_o, bus.wrreq_o);
      end
      drive(4'b0000, 4'b0000, 1'b0);
   endtask

   initial begin
      test_reset();
      test_single_packet();
      test_round_robin();
      test_stall();
      test_req_drop();
      test_reset_mid_packet();
      test_watchdog();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/noc_out_port_arbiter.md
Name: noc_out_port_arbiter

Overview:
- Per-output-port wormhole arbiter for the NoC router. It shares one tx link PHY among NUM_REQ input-port receive FIFOs.
- Round-robin selection. The grant is locked for a whole packet, from the first flit until the flit flagged last.
- It generates the rx FIFO pops and the tx write strobe for the granted input, and honours downstream stall.
- One instance sits in the router core for each tx port, between the rx FIFO outputs and the tx link PHY.

Parameters:
- NUM_REQ, 4, number of requesting input ports (2..16).
- REQ_IDX_W, $clog2(NUM_REQ), width of the index outputs.
- WDOG_CYCLES, 1024, maximum consecutive no-transfer cycles while locked (used only with ARB_WATCHDOG_EN).

Ports:
- clk_i  in  1  router clock
- reset_i  in  1  synchronous, active-high reset
- req_i  in  NUM_REQ  per input: flit available (inverse of that rx FIFO's empty flag) and routed to this port
- last_i  in  NUM_REQ  per input: flit at the FIFO head is the tail of its packet
- stall_i  in  1  tx link PHY cannot accept a flit this cycle
- grant_o  out  NUM_REQ  one-hot grant, registered
- sel_o  out  REQ_IDX_W  index of the granted input (drives the header/payload mux)
- rdreq_o  out  NUM_REQ  pop strobe to the granted rx FIFO
- wrreq_o  out  1  write strobe to the tx link PHY
- busy_o  out  1  a packet is in progress (state LOCKED)
- wdog_err_o  out  1  one-cycle pulse when a locked packet is forcibly released

Behaviour:
- Reset, applied synchronously at any time including mid-packet:
  - state IDLE; grant_o=0; sel_o=0; busy_o=0; wdog_err_o=0.
  - Round-robin pointer ptr=0; watchdog counter=0.
  - rdreq_o=0 and wrreq_o=0 in the reset cycle.
- States: IDLE, LOCKED.
- IDLE:
  - If any req_i bit is set, pick the first set bit searching upward from ptr, wrapping NUM_REQ-1 to 0.
  - Register grant_o=onehot(g) and sel_o=g; go to LOCKED on the next edge.
  - No transfers happen in IDLE. Latency is 1 cycle from req to grant, so the earliest wrreq_o is the cycle grant_o is visible.
- LOCKED, granted input g:
  - xfer = req_i[g] & ~stall_i, combinational.
  - rdreq_o[g] = wrreq_o = xfer. All other rdreq_o bits are 0.
  - If xfer & last_i[g]: go to IDLE, clear grant_o, set ptr=(g+1) mod NUM_REQ.
  - Otherwise stay LOCKED. This includes req_i[g] low (FIFO empty mid-packet): grant is held and no pop occurs.
- stall_i & last_i[g]: no transfer, stay LOCKED. The tail is sent on the first non-stalled cycle.
- Single-flit packet (first flit also last): a one-transfer lock, then IDLE.
- Packet-to-packet gap is exactly 1 bubble cycle (the IDLE arbitration cycle). Same-source back-to-back packets are allowed if no other input requests.
- Requests from non-granted inputs never affect the locked grant.
- ptr only advances on packet completion or watchdog release. It never advances on idle cycles.
- Invariants:
  - grant_o is zero or one-hot.
  - wrreq_o == |rdreq_o.
  - wrreq_o is never asserted while stall_i=1.

Optional Feature:
- Macro ARB_WATCHDOG_EN.
- Defined:
  - In LOCKED, a counter increments on every cycle without xfer and clears on every xfer.
  - When it reaches WDOG_CYCLES-1 on a non-xfer cycle: release to IDLE, ptr=(g+1) mod NUM_REQ, pulse wdog_err_o for 1 cycle, counter=0.
  - An xfer in the same cycle takes priority: counter clears and there is no release.
- Not defined:
  - No counter logic; wdog_err_o is tied to 0.
  - The lock is held indefinitely until the tail flit.

Test Plan:
- Reset, then req_i=4'b0100 with a 3-flit packet (last on flit 3) and stall_i=0:
  - grant_o=4'b0100 one cycle after req.
  - wrreq_o/rdreq_o[2] high 3 consecutive cycles.
  - IDLE after that; ptr=3.
- All four inputs request continuously with 2-flit packets: grant order 0,1,2,3,0, each separated by exactly one IDLE cycle.
- Input 1 is locked and stall_i is high for 5 cycles over the tail flit:
  - wrreq_o=0 during the stall.
  - Tail is sent on the first cycle stall_i=0, then IDLE.
- Input 3 is locked and req_i[3] drops for 4 cycles mid-packet while input 0 requests:
  - grant stays 4'b1000 and no pops occur.
  - Resumes; next grant is input 0 (wrap-around).
- reset_i is asserted in the second flit of a 4-flit packet:
  - next cycle grant_o=0, wrreq_o=0, ptr=0.
  - With req_i=4'b0011, the first grant is input 0.
- With ARB_WATCHDOG_EN and WDOG_CYCLES=8: input 2 locked and req_i[2]=0 for 8 cycles:
  - wdog_err_o pulses once on the 8th cycle.
  - Grant released; with req_i[3]=1 pending, the next grant is input 3.
  - Without the macro: grant held and wdog_err_o=0 throughout.
